prog_loader: RTL and testbench
==============================

# prog_loader

Boot-time program loader sitting directly upstream of the CPU core. It accepts a framed byte stream over a valid/ready handshake and writes the payload into instruction/data memory through a dedicated write port. It verifies an 8-bit checksum and holds the CPU in reset until a load has completed cleanly. Word width is `DATA_WIDTH` (8): one stream byte is one memory word.

## Interface

Parameters:
- ADDR_WIDTH, default `ADDR_WIDTH` (5): memory address width; legal range 1..7.
- TIMEOUT, default 255: maximum number of consecutive idle cycles without a transfer while a load is active; legal range 1..65535.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle request to begin a load.
- in_valid  in  1  stream byte valid.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts a byte this cycle.
- mem_wr  out  1  memory write strobe.
- mem_addr  out  ADDR_WIDTH  write address.
- mem_data  out  `DATA_WIDTH`  write data.
- cpu_rst_n  out  1  active-low CPU reset request.
- done  out  1  last load succeeded.
- err  out  1  last load failed.
- err_code  out  2  failure cause: 01 = LEN, 10 = CSUM, 11 = TIMEOUT, 00 = none.

## Operation

- **Frame format:** the frame is sent in this order:
  - HDR byte N: word count, legal range 1..2^ADDR_WIDTH.
  - N payload bytes, written to addresses 0..N-1 in order.
  - One checksum byte, equal to the sum of the payload bytes mod 256.
- **Transfer rule:** a transfer occurs on a cycle where in_valid=1 and in_ready=1. in_ready=1 exactly in states HDR, DATA and CSUM. in_valid while in_ready=0 is ignored.
- **IDLE:**
  - start moves to HDR.
  - done, err and err_code are cleared.
  - addr and sum are cleared.
  - cpu_rst_n=0.
- **HDR:**
  - On transfer, if N is 0 or greater than 2^ADDR_WIDTH, go to ERR with code LEN.
  - Otherwise latch remaining=N and go to DATA.
- **DATA:**
  - Each transfer writes the byte to mem_data at addr.
  - sum += byte (8-bit wrap); addr += 1; remaining -= 1.
  - When remaining reaches 0, go to CSUM.
- **CSUM:** on transfer, go to DONE if the byte equals sum; otherwise go to ERR with code CSUM.
- **DONE:** done=1, cpu_rst_n=1.
- **ERR:** err=1, err_code held, cpu_rst_n=0.
- **Restart:** start in DONE or ERR behaves as in IDLE: flags clear, cpu_rst_n drops to 0, go to HDR. start in HDR, DATA or CSUM is ignored.
- **Timeout:**
  - An idle counter runs only in HDR, DATA and CSUM.
  - It clears on every transfer and on entry to HDR.
  - It increments on every cycle without a transfer.
  - When it reaches TIMEOUT, go to ERR with code TIMEOUT.
  - If a transfer and the timeout fall in the same cycle, the transfer wins.
- **Partial loads:** memory words written before an error are not rolled back.

## Timing

- **Reset values:** on rst=0 all outputs go to 0 asynchronously (in_ready, mem_wr, mem_addr, mem_data, cpu_rst_n, done, err, err_code) and the state becomes IDLE. Reset mid-load abandons the frame.
- **start to in_ready:** start sampled at edge k gives in_ready=1 from cycle k+1.
- **Memory write:** mem_wr, mem_addr and mem_data are registered. A payload transfer at edge k gives a single-cycle mem_wr in cycle k+1. Back-to-back transfers give back-to-back writes with sequential addresses.
- **Completion:** the checksum transfer at edge k gives done=1 (or err=1) and the final cpu_rst_n value from cycle k+1.
- **Error flags:** an error sets err/err_code in the cycle after the detecting edge. in_ready drops in that same cycle.
- **Throughput:** one byte per cycle; a frame of N words needs at least N+2 transfer cycles.
- **Steady-state outputs:** done, err and cpu_rst_n are level outputs, stable until the next start or reset.

## Structure

- **Shared constants (def.v):** add the state encodings (`LD_IDLE, `LD_HDR, `LD_DATA, `LD_CSUM, `LD_DONE, `LD_ERR) and the error codes (`LD_ERR_LEN, `LD_ERR_CSUM, `LD_ERR_TO). Reuse `ADDR_WIDTH and `DATA_WIDTH.
- **Sub-module `loader_timer`:**
  - Inputs: clk, rst, enable, clear.
  - Output: expired.
  - Parameterised by TIMEOUT, counter width 16.
- **Top-level integration:** the top level muxes mem_wr/mem_addr/mem_data into the memory port while cpu_rst_n=0.

## Test plan

- **Good load:**
  - Stimulus: start, then bytes 03, 11, 22, 33, 66, streamed back-to-back.
  - Response: writes 11@0, 22@1, 33@2 on consecutive cycles; done=1 and cpu_rst_n=1 one cycle after byte 66; err=0.
- **Bad checksum:**
  - Stimulus: start, then 02, 10, 20, 31.
  - Response: two writes occur; err=1, err_code=10, cpu_rst_n stays 0.
- **Bad length:** header 00, and separately header 21 (hex) with ADDR_WIDTH=5 → err_code=01; no mem_wr, and in_ready=0 afterwards.
- **Timeout:**
  - Stimulus: TIMEOUT=8; start, then 04, 01, then in_valid held low.
  - Response: err_code=11 after exactly 8 idle cycles. Separately, a transfer on the 8th idle cycle is accepted and no error is raised.
- **Reset mid-load:**
  - Stimulus: assert rst low during DATA, release, then start with a good frame 01, 5A, 5A.
  - Response: all outputs 0 during reset; the reload writes 5A@0 and ends in done=1.
- **Ignored inputs:**
  - start pulsed during DATA is ignored and the frame continues.
  - in_valid with in_ready=0 in IDLE/DONE produces no write.
  - A restart from DONE drops cpu_rst_n the next cycle.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared constants for the boot-time program loader: state and error encodings,
// word width and the header length check.
package prog_loader_pkg;

  localparam int DATA_WIDTH    = 8;
  localparam int LD_ADDR_WIDTH = 5;

  typedef enum logic [2:0] {
    LD_IDLE = 3'd0,
    LD_HDR  = 3'd1,
    LD_DATA = 3'd2,
    LD_CSUM = 3'd3,
    LD_DONE = 3'd4,
    LD_ERR  = 3'd5
  } ld_state_e;

  typedef enum logic [1:0] {
    LD_ERR_NONE = 2'b00,
    LD_ERR_LEN  = 2'b01,
    LD_ERR_CSUM = 2'b10,
    LD_ERR_TO   = 2'b11
  } ld_err_e;

  // A header is legal when 1 <= N <= 2^aw.
  function automatic logic len_ok(input logic [DATA_WIDTH-1:0] n, input int aw);
    return (n != '0) && (int'(n) <= (1 << aw));
  endfunction

endpackage

// File: rtl/prog_loader_timer.sv
// Idle-cycle watchdog: counts cycles without a transfer and flags the cycle in
// which the TIMEOUT-th consecutive idle cycle completes.
module loader_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  logic [15:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 16'd1;
    end
  end

  // Fires during the last idle cycle so the FSM leaves on that same edge.
  assign expired = enable && !clear && (cnt == 16'(TIMEOUT - 1));

endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader: parses a framed byte stream, writes the payload to
// memory, verifies the checksum and releases the CPU reset on a clean load.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = LD_ADDR_WIDTH,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  cpu_rst_n,
  output logic                  done,
  output logic                  err,
  output logic [1:0]            err_code
);

  ld_state_e st, nxt;
  ld_err_e   err_q, err_nxt;
  logic      set_err;
  logic      xfer, start_ok, to_expired;

  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH:0]   remaining;
  logic [DATA_WIDTH-1:0] sum;

  logic                  vld_p1;
  logic [ADDR_WIDTH-1:0] addr_p1;
  logic [DATA_WIDTH-1:0] data_p1;

  function automatic logic [DATA_WIDTH-1:0] sum8(input logic [DATA_WIDTH-1:0] a,
                                                 input logic [DATA_WIDTH-1:0] b);
    return a + b;
  endfunction

  assign in_ready = (st == LD_HDR) || (st == LD_DATA) || (st == LD_CSUM);
  assign xfer     = in_ready && in_valid;
  assign start_ok = start && ((st == LD_IDLE) || (st == LD_DONE) || (st == LD_ERR));

  loader_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .enable  (in_ready && !xfer),
    .clear   (xfer || start_ok),
    .expired (to_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st    <= LD_IDLE;
      err_q <= LD_ERR_NONE;
    end else begin
      st <= nxt;
      if (start_ok) begin
        err_q <= LD_ERR_NONE;
      end else if (set_err) begin
        err_q <= err_nxt;
      end
    end
  end

  always_comb begin
    nxt     = st;
    set_err = 1'b0;
    err_nxt = LD_ERR_NONE;
    case (st)
      LD_IDLE, LD_DONE, LD_ERR: begin
        if (start) nxt = LD_HDR;
      end
      LD_HDR: begin
        if (xfer) begin
          if (len_ok(in_data, ADDR_WIDTH)) begin
            nxt = LD_DATA;
          end else begin
            set_err = 1'b1;
            err_nxt = LD_ERR_LEN;
          end
        end else if (to_expired) begin
          set_err = 1'b1;
          err_nxt = LD_ERR_TO;
        end
      end
      LD_DATA: begin
        if (xfer) begin
          if (remaining == {{ADDR_WIDTH{1'b0}}, 1'b1}) nxt = LD_CSUM;
        end else if (to_expired) begin
          set_err = 1'b1;
          err_nxt = LD_ERR_TO;
        end
      end
      LD_CSUM: begin
        if (xfer) begin
          if (in_data == sum) begin
            nxt = LD_DONE;
          end else begin
            set_err = 1'b1;
            err_nxt = LD_ERR_CSUM;
          end
        end else if (to_expired) begin
          set_err = 1'b1;
          err_nxt = LD_ERR_TO;
        end
      end
      default: nxt = LD_IDLE;
    endcase
    if (set_err) nxt = LD_ERR;
  end

  // stage p0 -> p1: payload transfer registered into the memory write port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr      <= '0;
      sum       <= '0;
      remaining <= '0;
      vld_p1    <= 1'b0;
      addr_p1   <= '0;
      data_p1   <= '0;
    end else begin
      vld_p1 <= 1'b0;
      if (start_ok || (st == LD_IDLE)) begin
        addr <= '0;
        sum  <= '0;
      end
      if (xfer && (st == LD_HDR)) begin
        remaining <= in_data[ADDR_WIDTH:0];
      end
      if (xfer && (st == LD_DATA)) begin
        vld_p1    <= 1'b1;
        addr_p1   <= addr;
        data_p1   <= in_data;
        addr      <= addr + 1'b1;
        sum       <= sum8(sum, in_data);
        remaining <= remaining - 1'b1;
      end
    end
  end

  assign cpu_rst_n = (st == LD_DONE);
  assign done      = (st == LD_DONE);
  assign err       = (st == LD_ERR);
  assign err_code  = err_q;

  // The loader owns the memory port only while the CPU is held in reset.
  assign mem_wr   = vld_p1 && !cpu_rst_n;
  assign mem_addr = cpu_rst_n ? '0 : addr_p1;
  assign mem_data = cpu_rst_n ? '0 : data_p1;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: good/bad frames, timeout, reset mid-load and
// ignored inputs, with writes captured by a monitor queue.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, mem_wr, cpu_rst_n, done, err;
  logic [4:0] mem_addr;
  logic [7:0] mem_data;
  logic [1:0] err_code;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  typedef struct {
    int         c;
    logic [4:0] a;
    logic [7:0] d;
  } wr_t;
  wr_t wq[$];

  prog_loader #(.ADDR_WIDTH(5), .TIMEOUT(8)) dut (
    .clk       (clk),
    .rst       (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .cpu_rst_n (cpu_rst_n),
    .done      (done),
    .err       (err),
    .err_code  (err_code)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n && mem_wr) wq.push_back('{c: cyc, a: mem_addr, d: mem_data});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // {in_ready, mem_wr, cpu_rst_n, done, err, err_code}
  function automatic logic [31:0] flags();
    return {25'd0, in_ready, mem_wr, cpu_rst_n, done, err, err_code};
  endfunction

  initial begin
    #2;
    check("reset_outputs", {flags(), 11'd0, mem_addr, mem_data}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // in_valid while idle must be ignored
    in_valid = 1'b1; in_data = 8'h77;
    repeat (3) tick();
    in_valid = 1'b0;
    check("idle_no_write", wq.size(), 0);
    check("idle_flags", flags(), 32'h00);

    // good load 03 11 22 33 66
    do_start();
    check("start_ready", in_ready, 1);
    send(8'h03); send(8'h11); send(8'h22); send(8'h33);
    check("pre_csum_cpu_rst", {cpu_rst_n, done}, 0);
    send(8'h66);
    check("good_flags", flags(), 32'h18);
    check("good_nwr", wq.size(), 3);
    if (wq.size() == 3) begin
      check("good_wr0", {wq[0].a, wq[0].d}, {5'd0, 8'h11});
      check("good_wr1", {wq[1].a, wq[1].d}, {5'd1, 8'h22});
      check("good_wr2", {wq[2].a, wq[2].d}, {5'd2, 8'h33});
      check("good_b2b", {wq[1].c - wq[0].c, wq[2].c - wq[1].c}, {32'd1, 32'd1});
    end

    // in_valid in DONE ignored, then restart drops cpu_rst_n
    wq.delete();
    in_valid = 1'b1; in_data = 8'hAA;
    repeat (3) tick();
    in_valid = 1'b0;
    check("done_no_write", wq.size(), 0);
    check("done_hold", flags(), 32'h18);
    do_start();
    check("restart_flags", flags(), 32'h40);

    // bad checksum 02 10 20 31
    send(8'h02); send(8'h10); send(8'h20); send(8'h31);
    check("csum_flags", flags(), 32'h06);
    check("csum_nwr", wq.size(), 2);
    if (wq.size() == 2) begin
      check("csum_wr0", {wq[0].a, wq[0].d}, {5'd0, 8'h10});
      check("csum_wr1", {wq[1].a, wq[1].d}, {5'd1, 8'h20});
    end

    // bad lengths 00 and 21
    wq.delete();
    do_start();
    check("len0_restart_code", err_code, 0);
    send(8'h00);
    check("len0_flags", flags(), 32'h05);
    do_start();
    send(8'h21);
    check("len21_flags", flags(), 32'h05);
    tick();
    check("len_no_write", wq.size(), 0);

    // timeout after exactly 8 idle cycles
    do_start();
    send(8'h04); send(8'h01);
    repeat (7) tick();
    check("to_not_yet", {in_ready, err}, 2'b10);
    tick();
    check("to_flags", flags(), 32'h07);

    // transfer on the 8th idle cycle wins; start during DATA ignored
    wq.delete();
    do_start();
    send(8'h04); send(8'h01);
    repeat (7) tick();
    send(8'h02);
    check("to_race_ok", {in_ready, err}, 2'b10);
    start = 1'b1;
    send(8'h03);
    start = 1'b0;
    send(8'h04); send(8'h0A);
    check("to_race_done", flags(), 32'h18);
    check("to_race_nwr", wq.size(), 4);

    // reset mid-load, then reload 01 5A 5A
    do_start();
    send(8'h03); send(8'hAA);
    rst_n = 1'b0;
    #2;
    check("midreset_outputs", {flags(), 11'd0, mem_addr, mem_data}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    wq.delete();
    do_start();
    send(8'h01); send(8'h5A); send(8'h5A);
    check("reload_flags", flags(), 32'h18);
    check("reload_nwr", wq.size(), 1);
    if (wq.size() == 1) check("reload_wr0", {wq[0].a, wq[0].d}, {5'd0, 8'h5A});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
